mult_seq_ctrl: RTL

- Control FSM that sits directly upstream of the 32-bit shift-add multiplier datapath and drives all of its load/enable strobes.
- Accepts a start request, then sequences operand load, conditional add and shift for each multiplier bit.
- Watches the datapath's iteration counter and product LSB, and signals completion.
- Together with the datapath it forms the complete sequential multiplier.

---
 rtl/mult_seq_ctrl_if.sv | 28 ++
 rtl/mult_seq_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Strobe/status bundle between the multiplier controller (master) and its shift-add datapath
// (slave).
interface mult_seq_ctrl_if #(
  parameter int unsigned CNT_W = 6
);
  logic             start;
  logic             prod_lsb;
  logic [CNT_W-1:0] counter;
  logic             busy;
  logic             done;
  logic             ldrstcounter;
  logic             ldencounter;
  logic             ldp;
  logic             ldsum;
  logic             ldlier;
  logic             ldcand;
  logic             ldshift;

  modport master (
    input  start, prod_lsb, counter,
    output busy, done, ldrstcounter, ldencounter, ldp, ldsum, ldlier, ldcand, ldshift
  );

  modport slave (
    output start, prod_lsb, counter,
    input  busy, done, ldrstcounter, ldencounter, ldp, ldsum, ldlier, ldcand, ldshift
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Moore control FSM for the sequential shift-add multiplier datapath.
// Optional MULT_PERF_CNT_EN adds an op_cycles output reporting the latency of the last operation.
module mult_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  mult_seq_ctrl_if.master   bus
`ifdef MULT_PERF_CNT_EN
  ,
  output logic [7:0]        op_cycles
`endif
);

  typedef enum logic [2:0] {StIdle, StLoad, StTest, StAdd, StShift, StDone} state_e;

  state_e st_q, st_d;

  always_ff @(posedge clk) begin
    if (rst) st_q <= StIdle;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:  if (bus.start) st_d = StLoad;
      StLoad:  st_d = StTest;
      // >= so a runaway datapath counter still terminates the operation
      StTest: begin
        if (bus.counter >= CNT_W'(WIDTH)) st_d = StDone;
        else if (bus.prod_lsb)             st_d = StAdd;
        else                               st_d = StShift;
      end
      StAdd:   st_d = StShift;
      StShift: st_d = StTest;
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy         = (st_q != StIdle);
    bus.done         = 1'b0;
    bus.ldrstcounter = 1'b0;
    bus.ldencounter  = 1'b0;
    bus.ldp          = 1'b0;
    bus.ldsum        = 1'b0;
    bus.ldlier       = 1'b0;
    bus.ldcand       = 1'b0;
    bus.ldshift      = 1'b0;
    unique case (st_q)
      StLoad: begin
        bus.ldlier       = 1'b1;
        bus.ldcand       = 1'b1;
        bus.ldp          = 1'b1;
        bus.ldrstcounter = 1'b1;
      end
      StAdd: begin
        bus.ldp   = 1'b1;
        bus.ldsum = 1'b1;
      end
      StShift: begin
        bus.ldshift     = 1'b1;
        bus.ldencounter = 1'b1;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

`ifdef MULT_PERF_CNT_EN
  logic [7:0] cyc_q, cyc_d;
  logic [7:0] op_cycles_q, op_cycles_d;

  // cyc_q holds the 1-based index of the current cycle since LOAD entry.
  always_comb begin
    cyc_d       = cyc_q;
    op_cycles_d = op_cycles_q;
    if (st_q == StIdle) begin
      if (st_d == StLoad) cyc_d = 8'd1;
    end else begin
      cyc_d = cyc_q + 8'd1;
    end
    if (st_q != StDone && st_d == StDone) op_cycles_d = cyc_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q       <= 8'd0;
      op_cycles_q <= 8'd0;
    end else begin
      cyc_q       <= cyc_d;
      op_cycles_q <= op_cycles_d;
    end
  end

  assign op_cycles = op_cycles_q;
`endif

endmodule
